rx_mac: RTL

- Receive-direction 10G Ethernet MAC. Consumes 64-bit XGMII words from the PHY (PCS decoder/gearbox) and produces an AXI-Stream master of frame payload bytes.
- Strips the preamble, SFD and FCS, checks the CRC-32 using the shared crc32 module, and flags bad frames on tuser with the tlast beat.
- Sits between the PHY receive path and user logic. It is the counterpart of the transmit MAC.

---
 rtl/rx_mac.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rx_mac.sv
// rx_mac: 10G XGMII receive MAC with preamble/FCS stripping, CRC-32 check and AXI-Stream payload output
module crc32 #(
  parameter int INPUT_WIDTH_BYTES = 8
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           clr,
  input  logic                           en,
  input  logic [8*INPUT_WIDTH_BYTES-1:0] data,
  input  logic [INPUT_WIDTH_BYTES-1:0]   keep,
  output logic [31:0]                    crc_next
);
  logic [31:0] state, nxt;
  always_comb begin
    nxt = state;
    for (int i = 0; i < INPUT_WIDTH_BYTES; i++)
      if (keep[i]) begin
        nxt = nxt ^ {24'd0, data[8*i +: 8]};
        for (int b = 0; b < 8; b++) nxt = nxt[0] ? (nxt >> 1) ^ 32'hEDB88320 : nxt >> 1;
      end
  end
  always_ff @(posedge i_clk)
    if (i_reset || clr) state <= '1;
    else if (en) state <= nxt;
  assign crc_next = ~nxt;
endmodule

module rx_mac #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic        phy_rx_valid,
  output logic [63:0] m00_axis_tdata,
  output logic [7:0]  m00_axis_tkeep,
  output logic        m00_axis_tvalid,
  output logic        m00_axis_tlast,
  output logic        m00_axis_tuser
);
  localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;
  state_t st;
  logic [63:0] d1, hd;
  logic [7:0] c1, xk, bk;
  logic hv, xv, xerr, bv, bl, babort, bchk, buser;
  logic [31:0] xfcs, fcs, crc_next;
  logic [15:0] cnt, cnt_n;
  logic [16:0] sum;
  logic [2:0] k;
  logic [6:0] fidx;
  logic [127:0] cat;
  logic has_fe, has_fd, is_data, is_term, is_start, bad_start, is_idle, over, runt;
  // k is the first control lane of the word in stage 1; a terminate must sit there
  always_comb begin
    k = '0;
    has_fe = 1'b0;
    has_fd = 1'b0;
    for (int i = 7; i >= 0; i--) if (c1[i]) k = 3'(i);
    for (int i = 0; i < 8; i++) begin
      has_fe = has_fe | (c1[i] && d1[8*i +: 8] == 8'hFE);
      has_fd = has_fd | (c1[i] && d1[8*i +: 8] == 8'hFD);
    end
  end
  assign is_data   = c1 == 8'h00;
  assign is_term   = (|c1) && d1[{k, 3'b000} +: 8] == 8'hFD && !has_fe;
  assign is_start  = c1 == 8'h01 && d1 == START_WORD;
  assign bad_start = (c1[0] && d1[7:0] == 8'hFB) || (c1[4] && d1[39:32] == 8'hFB);
  assign is_idle   = c1 == 8'hFF && d1 == {8{8'h07}};
  assign sum       = {1'b0, cnt} + (is_data ? 17'd8 : {14'd0, k});
  assign cnt_n     = sum[16] ? 16'hFFFF : sum[15:0];
  assign over      = cnt_n > 16'(MAX_FRAME_BYTES);
  assign runt      = cnt_n < 16'(MIN_FRAME_BYTES);
  // FCS occupies the four bytes just before the terminate, spanning held and current words
  assign cat  = {d1, hd};
  assign fidx = {1'b0, k, 3'b000} + 7'd32;
  assign fcs  = cat[fidx +: 32];
  always_comb begin
    bv = 1'b0;
    bk = 8'hFF;
    bl = 1'b0;
    babort = 1'b0;
    bchk = 1'b0;
    if (xv) begin
      bv = 1'b1;
      bk = xk;
      bl = 1'b1;
      bchk = 1'b1;
    end else if (st == DATA && hv) begin
      bv = 1'b1;
      if (is_term && !over) begin
        bl = k <= 3'd4;
        bk = k <= 3'd4 ? 8'hFF >> (3'd4 - k) : 8'hFF;
        bchk = k <= 3'd4;
      end else if (!(is_data && !over)) begin
        bl = 1'b1;
        babort = 1'b1;
      end
    end
  end
  assign buser = babort | (bchk & (((xv ? xfcs : fcs) != crc_next) | (xv ? xerr : runt)));
  crc32 #(.INPUT_WIDTH_BYTES(8)) u_crc (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .clr(phy_rx_valid && st == IDLE && is_start),
    .en(phy_rx_valid && bv),
    .data(hd),
    .keep(bk),
    .crc_next(crc_next)
  );
  always_ff @(posedge i_clk)
    if (i_reset) begin
      st <= IDLE;
      d1 <= '0;
      c1 <= '0;
      hd <= '0;
      hv <= 1'b0;
      xv <= 1'b0;
      xk <= '0;
      xfcs <= '0;
      xerr <= 1'b0;
      cnt <= '0;
      m00_axis_tdata <= '0;
      m00_axis_tkeep <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast <= 1'b0;
      m00_axis_tuser <= 1'b0;
    end else if (phy_rx_valid) begin
      d1 <= xgmii_rxd;
      c1 <= xgmii_rxc;
      m00_axis_tvalid <= bv;
      m00_axis_tdata <= hd;
      m00_axis_tkeep <= bv ? bk : 8'h00;
      m00_axis_tlast <= bl;
      m00_axis_tuser <= bl & buser;
      xv <= 1'b0;
      case (st)
        IDLE:
          if (is_start) begin
            st <= DATA;
            cnt <= '0;
            hv <= 1'b0;
          end else if (bad_start) st <= DROP;
        DATA:
          if (is_data && !over) begin
            hd <= d1;
            hv <= 1'b1;
            cnt <= cnt_n;
          end else if (is_term && !over) begin
            st <= IDLE;
            hv <= 1'b0;
            if (hv && k > 3'd4) begin
              xv <= 1'b1;
              hd <= d1;
              xk <= 8'hFF >> (4'd12 - {1'b0, k});
              xfcs <= fcs;
              xerr <= runt;
            end
          end else begin
            st <= DROP;
            hv <= 1'b0;
          end
        DROP: if (is_idle || has_fd) st <= IDLE;
        default: st <= IDLE;
      endcase
    end else begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast <= 1'b0;
      m00_axis_tuser <= 1'b0;
    end
endmodule
